// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// field widths, the latched request record and the address legality check.
package mem_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // A byte address is illegal when it is odd or its word index exceeds the array.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a, input int depth);
    return a[0] || (int'(a[ADDR_W-1:1]) >= depth);
  endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous word array with a registered read port.
// Optional feature macro: MEM_PARITY_EN adds an even-parity bit per word and
// a registered parity-error flag that is valid the cycle after a read.
module mem_array_sp
  import mem_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int INIT_ZERO = 1,
  parameter int IDX_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              perr
);

`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] wword;
  logic [DATA_W-1:0] rdata_q;
  logic              perr_q, perr_d;

  // Stored word image and read-side parity check (whole word XOR must be 0).
  always_comb begin
`ifdef MEM_PARITY_EN
    wword  = {^wdata, wdata};
    perr_d = en && !we && (^mem_q[idx]);
`else
    wword  = wdata;
    perr_d = 1'b0;
`endif
  end

  // Array write port; with INIT_ZERO the reset also clears the parity bits.
  generate
    if (INIT_ZERO != 0) begin : g_init
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (en && we) begin
          mem_q[idx] <= wword;
        end
      end
    end else begin : g_noinit
      always_ff @(posedge clk) begin
        if (en && we) mem_q[idx] <= wword;
      end
    end
  endgenerate

  // Read register holds its value until the next read; error flag is one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      if (en && !we) rdata_q <= mem_q[idx][DATA_W-1:0];
      perr_q <= perr_d;
    end
  end

  assign rdata = rdata_q;
  assign perr  = perr_q;

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: accepts a request, waits WAIT_CYCLES,
// then pulses ack for one cycle with read data and an error flag.
// Optional feature macro: MEM_PARITY_EN (per-word parity, reported on err).
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int INIT_ZERO   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  mem_req_t          lat_q, lat_d;
  mem_req_t          cur;
  logic              ack_q, ack_d, err_q, err_d, busy_q, busy_d;
  logic              go_resp, bad, mem_en, perr;

  // Next-state logic; the memory op fires on the edge that enters RESP,
  // using the incoming fields when accept and RESP entry coincide.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    cur     = lat_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          lat_d = '{we: we, addr: addr, wdata: wdata};
          cur   = lat_d;
          cnt_d = '0;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + WAIT_W'(1);
        if (cnt_q == WAIT_W'(WAIT_CYCLES - 1)) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    bad    = addr_bad(cur.addr, DEPTH);
    mem_en = go_resp && !bad;
    ack_d  = go_resp;
    err_d  = go_resp && bad;
    busy_d = (state_d != IDLE);
  end

  // FSM, counter, request latch and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  mem_array_sp #(
    .DEPTH    (DEPTH),
    .INIT_ZERO(INIT_ZERO),
    .IDX_W    (IDX_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .en   (mem_en),
    .we   (cur.we),
    .idx  (cur.addr[IDX_W:1]),
    .wdata(cur.wdata),
    .rdata(rdata),
    .perr (perr)
  );

  // perr is only ever high in the cycle after a read, i.e. the ack cycle.
  assign ack  = ack_q;
  assign err  = err_q | perr;
  assign busy = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: table vectors, corner
// sequences (input scramble, mid-flight reset, zero-wait streaming) and
// randomized traffic against an array-based reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, ack, err, busy;
  logic [14:0] addr;
  logic [15:0] wdata, rdata;
  logic        req0, we0, ack0, err0, busy0;
  logic [14:0] addr0;
  logic [15:0] wdata0, rdata0;

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl_mem [1024];
  logic [15:0] mdl_rd;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2), .INIT_ZERO(1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy)
  );

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0), .INIT_ZERO(1)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic        exp_err;
    logic [15:0] exp_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: word array + last-read register, straight from the access rules.
  task automatic model(input logic mwe, input logic [14:0] ma, input logic [15:0] mw,
                       output logic e, output logic [15:0] r);
    int ix;
    ix = int'(ma[14:1]);
    e  = ma[0] || (ix >= 1024);
    if (!e) begin
      if (mwe) mdl_mem[ix] = mw;
      else     mdl_rd = mdl_mem[ix];
    end
    r = mdl_rd;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) mdl_mem[i] = 16'h0000;
    mdl_rd = 16'h0000;
  endtask

  // One transaction on the 2-wait-state DUT; checks latency, busy and pulse width.
  task automatic txn(input logic twe, input logic [14:0] ta, input logic [15:0] tw,
                     input bit scr, output logic oerr, output logic [15:0] ord);
    int k;
    bit got;
    @(negedge clk);
    req = 1'b1; we = twe; addr = ta; wdata = tw;
    @(posedge clk);
    got = 1'b0; k = 0; oerr = 1'bx; ord = 'x;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (ack) begin
        got = 1'b1; oerr = err; ord = rdata;
        chk("busy_in_ack", busy, 1);
      end else begin
        chk("busy_wait", busy, 1);
        chk("err_without_ack", err, 0);
        if (scr) begin addr = 15'h0032; wdata = 16'hDEAD; end
      end
    end
    chk("ack_seen", got, 1);
    chk("latency", k, 3);
    req = 1'b0; addr = $urandom; wdata = $urandom;
    @(negedge clk);
    chk("ack_one_cycle", ack, 0);
    chk("busy_after", busy, 0);
  endtask

  vec_t        vt [10];
  logic        e_m, e_g;
  logic [15:0] r_m, r_g;
  int          acks;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 15'h0010, 16'hBEEF, 1'b0, 16'h0000};
    vt[1] = '{1'b0, 15'h0010, 16'h0000, 1'b0, 16'hBEEF};
    vt[2] = '{1'b0, 15'h0011, 16'h0000, 1'b1, 16'hBEEF};
    vt[3] = '{1'b1, 15'h0801, 16'hCAFE, 1'b1, 16'hBEEF};
    vt[4] = '{1'b0, 15'h0000, 16'h0000, 1'b0, 16'h0000};
    vt[5] = '{1'b1, 15'h07FE, 16'h1111, 1'b0, 16'h0000};
    vt[6] = '{1'b0, 15'h07FE, 16'h0000, 1'b0, 16'h1111};
    vt[7] = '{1'b0, 15'h0800, 16'h0000, 1'b1, 16'h1111};
    vt[8] = '{1'b1, 15'h0012, 16'h5A5A, 1'b0, 16'h1111};
    vt[9] = '{1'b0, 15'h0010, 16'h0000, 1'b0, 16'hBEEF};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    model_clear();
    #2 rst = 1'b0;
    #1;
    chk("rst_ack", ack, 0);   chk("rst_err", err, 0);
    chk("rst_busy", busy, 0); chk("rst_rdata", rdata, 16'h0000);
    chk("rst_ack0", ack0, 0); chk("rst_busy0", busy0, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      model(vt[i].we, vt[i].addr, vt[i].wdata, e_m, r_m);
      txn(vt[i].we, vt[i].addr, vt[i].wdata, 1'b0, e_g, r_g);
      chk($sformatf("tbl%0d_err", i), e_g, vt[i].exp_err);
      chk($sformatf("tbl%0d_rdata", i), r_g, vt[i].exp_rd);
    end

    // Fields changed after accept: write must land at the latched address only
    model(1'b1, 15'h0030, 16'h7777, e_m, r_m);
    txn(1'b1, 15'h0030, 16'h7777, 1'b1, e_g, r_g);
    chk("scr_wr_err", e_g, 0);
    txn(1'b0, 15'h0030, 16'h0000, 1'b0, e_g, r_g);
    chk("scr_rd_latched", r_g, 16'h7777);
    txn(1'b0, 15'h0032, 16'h0000, 1'b0, e_g, r_g);
    chk("scr_rd_other", r_g, 16'h0000);

    // Reset during WAIT of a write: no ack, busy drops, write dropped
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 15'h0020; wdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_rdata", rdata, 16'h0000);
    req = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b1;
      if (ack) acks++;
    end
    chk("mid_rst_no_ack", acks, 0);
    model_clear();
    txn(1'b0, 15'h0020, 16'h0000, 1'b0, e_g, r_g);
    chk("mid_rst_readback", r_g, 16'h0000);
    chk("mid_rst_rb_err", e_g, 0);

    // Zero wait states: one write, then req held across four reads
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0040; wdata0 = 16'hA5A5;
    @(negedge clk);
    chk("w0_wr_ack", ack0, 1);
    req0 = 1'b0;
    @(negedge clk);
    chk("w0_wr_gap", ack0, 0);
    req0 = 1'b1; we0 = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("w0_ack_s%0d", i), ack0, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("w0_busy_s%0d", i), busy0, (i % 2 == 0) ? 1 : 0);
      if (ack0) begin
        acks++;
        chk("w0_rdata", rdata0, 16'hA5A5);
        chk("w0_err", err0, 0);
      end
    end
    req0 = 1'b0;
    chk("w0_ack_count", acks, 4);

    // Randomized traffic against the model
    for (int n = 0; n < 80; n++) begin
      logic        rwe;
      logic [14:0] ra;
      logic [15:0] rw;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      ra = 15'($urandom_range(0, 127) | 1);
      else if (sel == 1) ra = 15'($urandom_range(2048, 32767));
      else               ra = 15'($urandom_range(0, 63) * 2);
      rwe = 1'($urandom_range(0, 1));
      rw  = 16'($urandom);
      model(rwe, ra, rw, e_m, r_m);
      txn(rwe, ra, rw, 1'($urandom_range(0, 1)), e_g, r_g);
      chk($sformatf("rnd%0d_err", n), e_g, e_m);
      chk($sformatf("rnd%0d_rdata", n), r_g, r_m);
    end

`ifdef MEM_PARITY_EN
    // Corrupt one stored data bit: parity error reported, data still returned
    txn(1'b1, 15'h0050, 16'h0F0F, 1'b0, e_g, r_g);
    dut.u_mem.mem_q[40][0] = ~dut.u_mem.mem_q[40][0];
    txn(1'b0, 15'h0050, 16'h0000, 1'b0, e_g, r_g);
    chk("par_err", e_g, 1);
    chk("par_rdata", r_g, 16'h0F0E);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
